// File: rtl/cl_ocl_reg_pkg.sv
// Shared definitions for the OCL register responder: register map, AXI response
// codes, read-channel states and byte-lane helpers.
package cl_ocl_reg_pkg;

    localparam logic [15:0] ADDR_ID0   = 16'h0000;
    localparam logic [15:0] ADDR_ID1   = 16'h0004;
    localparam logic [15:0] ADDR_HELLO = 16'h0500;
    localparam logic [15:0] ADDR_CYCLE = 16'h0508;
    localparam logic [15:0] ADDR_WRCNT = 16'h050C;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    // Lanes with a set strobe take the new byte, the rest keep the old one.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] val);
        return {val[7:0], val[15:8], val[23:16], val[31:24]};
    endfunction

    function automatic logic [15:0] word_addr(input logic [13:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/cl_ocl_reg_slave.sv
// AXI4-Lite responder on the shell OCL BAR exposing ID, HELLO scratch, cycle
// counter and write counter; one outstanding read and one outstanding write.
module cl_ocl_reg_slave
    import cl_ocl_reg_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter logic [31:0] ID0           = 32'h0000_0000,
    parameter logic [31:0] ID1           = 32'h0000_0000,
    parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk_main_a0,
    input  logic              rst_main,
    input  logic [ADDR_W-1:0] sh_ocl_awaddr,
    input  logic              sh_ocl_awvalid,
    output logic              ocl_sh_awready,
    input  logic [31:0]       sh_ocl_wdata,
    input  logic [3:0]        sh_ocl_wstrb,
    input  logic              sh_ocl_wvalid,
    output logic              ocl_sh_wready,
    output logic [1:0]        ocl_sh_bresp,
    output logic              ocl_sh_bvalid,
    input  logic              sh_ocl_bready,
    input  logic [ADDR_W-1:0] sh_ocl_araddr,
    input  logic              sh_ocl_arvalid,
    output logic              ocl_sh_arready,
    output logic [31:0]       ocl_sh_rdata,
    output logic [1:0]        ocl_sh_rresp,
    output logic              ocl_sh_rvalid,
    input  logic              sh_ocl_rready,
    output logic [31:0]       hello_value
);

    logic        aw_held;
    logic        w_held;
    logic        bvalid_q;
    logic [13:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_avail;
    logic        w_avail;
    logic        commit;
    logic [15:0] wr_word;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic [31:0] hello_q;
    logic [31:0] cycle_q;
    logic [31:0] wrcnt_q;

    r_state_t    r_state;
    r_state_t    r_state_next;
    logic        ar_hs;
    logic [15:0] rd_word;
    logic [31:0] rd_value;
    logic [31:0] rdata_q;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{sh_ocl_awaddr[ADDR_W-1:16], sh_ocl_awaddr[1:0],
                                sh_ocl_araddr[ADDR_W-1:16], sh_ocl_araddr[1:0]};

    // Ready outputs are forced low during reset so nothing handshakes in that cycle.
    assign ocl_sh_awready = !aw_held && !bvalid_q && !rst_main;
    assign ocl_sh_wready  = !w_held  && !bvalid_q && !rst_main;
    assign ocl_sh_bvalid  = bvalid_q;
    assign ocl_sh_bresp   = OKAY;

    assign aw_hs    = sh_ocl_awvalid && ocl_sh_awready;
    assign w_hs     = sh_ocl_wvalid  && ocl_sh_wready;
    assign aw_avail = aw_held || aw_hs;
    assign w_avail  = w_held  || w_hs;

    // Commit on the edge where the second half arrives, so AW+W together give bvalid next cycle.
    assign commit  = aw_avail && w_avail;
    assign wr_word = word_addr(aw_held ? aw_addr_q : sh_ocl_awaddr[15:2]);
    assign wr_data = w_held ? w_data_q : sh_ocl_wdata;
    assign wr_strb = w_held ? w_strb_q : sh_ocl_wstrb;

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= sh_ocl_awaddr[15:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= sh_ocl_wdata;
                w_strb_q <= sh_ocl_wstrb;
            end
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            bvalid_q <= 1'b0;
        end else if (commit) begin
            bvalid_q <= 1'b1;
        end else if (bvalid_q && sh_ocl_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Every committed write bumps WRCNT, including read-only and unmapped targets.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            hello_q <= '0;
            wrcnt_q <= '0;
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (commit) begin
                wrcnt_q <= wrcnt_q + 32'd1;
                if (wr_word == ADDR_HELLO) begin
                    hello_q <= apply_wstrb(hello_q, wr_data, wr_strb);
                end
            end
        end
    end

    assign hello_value = hello_q;

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (sh_ocl_arvalid) r_state_next = R_RESP;
            R_RESP:  if (sh_ocl_rready)  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        ocl_sh_arready = 1'b0;
        ocl_sh_rvalid  = 1'b0;
        case (r_state)
            R_IDLE:  ocl_sh_arready = !rst_main;
            R_RESP:  ocl_sh_rvalid  = 1'b1;
            default: ocl_sh_arready = 1'b0;
        endcase
    end

    assign ar_hs   = sh_ocl_arvalid && ocl_sh_arready;
    assign rd_word = word_addr(sh_ocl_araddr[15:2]);

    // Registers are read before any same-cycle write lands, giving pre-write values.
    always_comb begin
        rd_value = UNMAPPED_DATA;
        case (rd_word)
            ADDR_ID0:   rd_value = ID0;
            ADDR_ID1:   rd_value = ID1;
            ADDR_HELLO: rd_value = byte_swap(hello_q);
            ADDR_CYCLE: rd_value = cycle_q;
            ADDR_WRCNT: rd_value = wrcnt_q;
            default:    rd_value = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            rdata_q <= '0;
        end else if (ar_hs) begin
            rdata_q <= rd_value;
        end
    end

    assign ocl_sh_rdata = rdata_q;
    assign ocl_sh_rresp = OKAY;

endmodule

// File: tb/tb_cl_ocl_reg_slave.sv
// Directed self-checking bench for cl_ocl_reg_slave: register map, write-channel
// ordering, backpressure, same-cycle read/write and reset mid-transaction.
module tb_cl_ocl_reg_slave;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] hello;

    int          num_checks;
    int          num_errors;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic [31:0] rd_cycle;
    logic [31:0] model_cycle;

    cl_ocl_reg_slave #(
        .ADDR_W        (32),
        .ID0           (32'hF000_1D0F),
        .ID1           (32'h1111_2222),
        .UNMAPPED_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk_main_a0    (clk),
        .rst_main       (rst),
        .sh_ocl_awaddr  (awaddr),
        .sh_ocl_awvalid (awvalid),
        .ocl_sh_awready (awready),
        .sh_ocl_wdata   (wdata),
        .sh_ocl_wstrb   (wstrb),
        .sh_ocl_wvalid  (wvalid),
        .ocl_sh_wready  (wready),
        .ocl_sh_bresp   (bresp),
        .ocl_sh_bvalid  (bvalid),
        .sh_ocl_bready  (bready),
        .sh_ocl_araddr  (araddr),
        .sh_ocl_arvalid (arvalid),
        .ocl_sh_arready (arready),
        .ocl_sh_rdata   (rdata),
        .ocl_sh_rresp   (rresp),
        .ocl_sh_rvalid  (rvalid),
        .sh_ocl_rready  (rready),
        .hello_value    (hello)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle reference: zero in the first cycle after a reset edge.
    always @(posedge clk) begin
        if (rst) model_cycle <= 32'd0;
        else     model_cycle <= model_cycle + 32'd1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // Single write with AW and W presented together; optional bready backpressure.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int bready_delay);
        int guard;
        guard   = 0;
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        while (!(awready && wready) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("aw_w_ready", {31'd0, awready && wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("bvalid_latency", {31'd0, bvalid}, 32'd1);
        checkOutput("bresp", {30'd0, bresp}, 32'd0);
        for (int i = 0; i < bready_delay; i++) begin
            @(posedge clk); #1;
            checkOutput("bvalid_hold", {31'd0, bvalid}, 32'd1);
            checkOutput("awready_blocked", {31'd0, awready}, 32'd0);
            checkOutput("wready_blocked", {31'd0, wready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("bvalid_clear", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic read_reg(input logic [31:0] addr, input int rready_delay,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic [31:0] cyc_at_hs);
        int guard;
        guard   = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("arready_idle", {31'd0, arready}, 32'd1);
        cyc_at_hs = model_cycle;
        @(posedge clk); #1;
        arvalid = 1'b0;
        checkOutput("rvalid_latency", {31'd0, rvalid}, 32'd1);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < rready_delay; i++) begin
            @(posedge clk); #1;
            checkOutput("rvalid_hold", {31'd0, rvalid}, 32'd1);
            checkOutput("rdata_stable", rdata, data);
            checkOutput("arready_busy", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checkOutput("rvalid_clear", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        rst     = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_arready", {31'd0, arready}, 32'd0);
        checkOutput("rst_awready", {31'd0, awready}, 32'd0);
        checkOutput("rst_wready", {31'd0, wready}, 32'd0);
        checkOutput("rst_bvalid", {31'd0, bvalid}, 32'd0);
        checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("rst_hello", hello, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_arready", {31'd0, arready}, 32'd1);
        checkOutput("post_rst_awready", {31'd0, awready}, 32'd1);

        read_reg(32'h0000_0000, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("id0", rd_data, 32'hF000_1D0F);
        checkOutput("id0_rresp", {30'd0, rd_resp}, 32'd0);

        applyStimulus(32'h0000_0500, 32'h1234_5678, 4'hF, 0);
        checkOutput("hello_full", hello, 32'h1234_5678);
        read_reg(32'h0000_0500, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("hello_swapped", rd_data, 32'h7856_3412);

        // W arrives two cycles ahead of AW on a freshly reset HELLO.
        apply_reset();
        wdata  = 32'hAABB_CCDD;
        wstrb  = 4'b0010;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        checkOutput("w_early_wready_held", {31'd0, wready}, 32'd0);
        checkOutput("w_early_no_bvalid", {31'd0, bvalid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("w_early_still_no_bvalid", {31'd0, bvalid}, 32'd0);
        awaddr  = 32'h0000_0500;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        checkOutput("aw_late_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("hello_strb_merge", hello, 32'h0000_CC00);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("aw_late_bvalid_clear", {31'd0, bvalid}, 32'd0);
        read_reg(32'h0000_050C, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("wrcnt_one", rd_data, 32'd1);

        applyStimulus(32'h0000_0004, 32'hCAFE_F00D, 4'hF, 10);
        read_reg(32'h0000_0004, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("id1_unchanged", rd_data, 32'h1111_2222);
        read_reg(32'h0000_050C, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("wrcnt_ro_write", rd_data, 32'd2);
        checkOutput("hello_after_ro_write", hello, 32'h0000_CC00);

        read_reg(32'h0000_0500, 5, rd_data, rd_resp, rd_cycle);
        checkOutput("hello_backpressure", rd_data, 32'h00CC_0000);
        read_reg(32'h0000_1234, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("unmapped_data", rd_data, 32'hDEAD_BEEF);
        checkOutput("unmapped_rresp", {30'd0, rd_resp}, 32'd0);
        read_reg(32'h0000_0503, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("low_addr_bits_ignored", rd_data, 32'h00CC_0000);
        read_reg(32'h0000_0508, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("cycle_at_ar", rd_data, rd_cycle);

        // Read and write to HELLO handshake on the same edge.
        araddr  = 32'h0000_0500;
        arvalid = 1'b1;
        awaddr  = 32'h0000_0500;
        awvalid = 1'b1;
        wdata   = 32'hFFFF_FFFF;
        wstrb   = 4'b1001;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("same_cycle_rvalid", {31'd0, rvalid}, 32'd1);
        checkOutput("same_cycle_bvalid", {31'd0, bvalid}, 32'd1);
        checkOutput("same_cycle_pre_write", rdata, 32'h00CC_0000);
        checkOutput("same_cycle_hello", hello, 32'hFF00_CCFF);
        bready = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        rready = 1'b0;
        checkOutput("same_cycle_rvalid_clear", {31'd0, rvalid}, 32'd0);
        checkOutput("same_cycle_bvalid_clear", {31'd0, bvalid}, 32'd0);
        read_reg(32'h0000_0500, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("hello_post_write", rd_data, 32'hFFCC_00FF);
        read_reg(32'h0000_050C, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("wrcnt_three", rd_data, 32'd3);

        // Reset while both a read and a write response are pending.
        araddr  = 32'h0000_0000;
        arvalid = 1'b1;
        awaddr  = 32'h0000_0500;
        awvalid = 1'b1;
        wdata   = 32'h0000_0001;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("pending_rvalid", {31'd0, rvalid}, 32'd1);
        checkOutput("pending_bvalid", {31'd0, bvalid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        checkOutput("midrst_bvalid", {31'd0, bvalid}, 32'd0);
        checkOutput("midrst_arready", {31'd0, arready}, 32'd0);
        checkOutput("midrst_hello", hello, 32'd0);
        rst    = 1'b0;
        bready = 1'b1;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("no_late_bvalid", {31'd0, bvalid}, 32'd0);
            checkOutput("no_late_rvalid", {31'd0, rvalid}, 32'd0);
        end
        bready = 1'b0;
        rready = 1'b0;
        read_reg(32'h0000_0508, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("cycle_restart", rd_data, 32'd3);
        read_reg(32'h0000_050C, 0, rd_data, rd_resp, rd_cycle);
        checkOutput("wrcnt_after_rst", rd_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
